ahb_replica_voter: RTL and testbench



---
 rtl/ahb_replica_voter_pkg.sv | 18 +
 rtl/lockstep_delay.sv | 39 +++
 rtl/ahb_replica_voter.sv | 142 ++++++++++++++
 tb/tb_ahb_replica_voter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_replica_voter_pkg.sv
// Shared hardisc lockstep definitions: bundle width, checker state type and a
// small helper used by the replica voter.
package p_hardisc;

    localparam int AHB_BUNDLE_W = 91;

    typedef enum logic [1:0] {
        LS_OK         = 2'd0,
        LS_CORRECTING = 2'd1,
        LS_FAILED     = 2'd2
    } lockstep_state_t;

    // Number of replicas disagreeing with the vote.
    function automatic logic [1:0] count3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/lockstep_delay.sv
// Reset-to-zero shift register, DELAY stages deep; DELAY=0 is a plain wire.
// Used to hold back the leading replica so all copies line up in time.
module lockstep_delay #(
    parameter int BUS_W = 91,
    parameter int DELAY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BUS_W-1:0] d,
    output logic [BUS_W-1:0] q
);

    generate
        if (DELAY == 0) begin : g_bypass
            assign q = d;
        end else begin : g_chain
            for (genvar gi = 0; gi < DELAY; gi++) begin : g_stage
                logic [BUS_W-1:0] stage_reg;
                logic [BUS_W-1:0] stage_next;

                if (gi == 0) begin : g_head
                    assign stage_next = d;
                end else begin : g_tail
                    assign stage_next = g_stage[gi-1].stage_reg;
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        stage_reg <= '0;
                    end else begin
                        stage_reg <= stage_next;
                    end
                end
            end
            assign q = g_stage[DELAY-1].stage_reg;
        end
    endgenerate

endmodule

// File: rtl/ahb_replica_voter.sv
// Aligns replicated AHB master bundles, votes them onto the bus and tracks
// correctable / unrecoverable discrepancies with a sticky-failure state machine.
module ahb_replica_voter
    import p_hardisc::*;
#(
    parameter int REPLICAS = 3,
    parameter int DELAY    = 2,
    parameter int BUS_W    = AHB_BUNDLE_W,
    parameter int MAX_RUN  = 4
) (
    input  logic             s_clk_i,
    input  logic             s_resetn_i,
    input  logic             s_cmp_en_i,
    input  logic [BUS_W-1:0] s_rep_i [REPLICAS],
    output logic [BUS_W-1:0] s_bus_o,
    output logic [1:0]       s_unrec_err_o,
    output logic             s_corr_o,
    output logic [1:0]       s_fault_rep_o,
    output logic [7:0]       s_corr_cnt_o
);

    localparam int WU_W    = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
    localparam int RUN_W   = $clog2(MAX_RUN + 1);
    localparam bit CHECKED = (REPLICAS > 1);

    logic [BUS_W-1:0] aligned [REPLICAS];
    logic [BUS_W-1:0] vote;
    logic [2:0]       rep_diff;
    logic [1:0]       n_diff;
    logic             corr_hit;
    logic             unrec_hit;
    logic [1:0]       corr_idx;
    logic             qualified;

    lockstep_state_t  state_reg, state_next;
    logic [RUN_W-1:0] run_reg, run_next;
    logic [WU_W-1:0]  warm_reg;
    logic             corr_reg, corr_next;
    logic             unrec_reg, unrec_next;
    logic [1:0]       fault_reg, fault_next;
    logic [7:0]       cnt_reg, cnt_next;

    // Replica 0 runs DELAY cycles ahead; the others are already aligned.
    lockstep_delay #(
        .BUS_W (BUS_W),
        .DELAY (DELAY)
    ) u_lead_delay (
        .clk   (s_clk_i),
        .rst_n (s_resetn_i),
        .d     (s_rep_i[0]),
        .q     (aligned[0])
    );

    generate
        for (genvar gi = 1; gi < REPLICAS; gi++) begin : g_live
            assign aligned[gi] = s_rep_i[gi];
        end

        if (REPLICAS == 3) begin : g_tmr
            assign vote = (aligned[0] & aligned[1]) |
                          (aligned[0] & aligned[2]) |
                          (aligned[1] & aligned[2]);
        end else begin : g_single
            assign vote = aligned[0];
        end

        for (genvar gi = 0; gi < 3; gi++) begin : g_diff
            if (gi < REPLICAS) begin : g_used
                assign rep_diff[gi] = (aligned[gi] != vote);
            end else begin : g_absent
                assign rep_diff[gi] = 1'b0;
            end
        end
    endgenerate

    assign s_bus_o   = vote;
    assign n_diff    = count3(rep_diff);
    assign corr_hit  = (REPLICAS == 3) && (n_diff == 2'd1);
    // With two replicas the vote is replica 0, so any disagreement is fatal.
    assign unrec_hit = (REPLICAS == 3) ? (n_diff >= 2'd2) : (n_diff != 2'd0);
    assign corr_idx  = rep_diff[1] ? 2'd1 : (rep_diff[2] ? 2'd2 : 2'd0);
    assign qualified = CHECKED && s_cmp_en_i && (warm_reg == '0);

    always_comb begin
        state_next = state_reg;
        run_next   = run_reg;
        corr_next  = 1'b0;
        unrec_next = 1'b0;
        fault_next = fault_reg;
        cnt_next   = cnt_reg;

        if (qualified && state_reg != LS_FAILED) begin
            if (unrec_hit) begin
                unrec_next = 1'b1;
                state_next = LS_FAILED;
            end else if (corr_hit) begin
                corr_next  = 1'b1;
                fault_next = corr_idx;
                if (cnt_reg != 8'hFF) begin
                    cnt_next = cnt_reg + 8'd1;
                end
                if (state_reg == LS_CORRECTING && corr_idx == fault_reg) begin
                    run_next = run_reg + RUN_W'(1);
                end else begin
                    run_next = RUN_W'(1);
                end
                state_next = (run_next == RUN_W'(MAX_RUN)) ? LS_FAILED : LS_CORRECTING;
            end else if (state_reg == LS_CORRECTING) begin
                state_next = LS_OK;
                run_next   = '0;
            end
        end
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state_reg <= LS_OK;
            run_reg   <= '0;
            warm_reg  <= WU_W'(DELAY);
            corr_reg  <= 1'b0;
            unrec_reg <= 1'b0;
            fault_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            run_reg   <= run_next;
            corr_reg  <= corr_next;
            unrec_reg <= unrec_next;
            fault_reg <= fault_next;
            cnt_reg   <= cnt_next;
            if (warm_reg != '0) begin
                warm_reg <= warm_reg - WU_W'(1);
            end
        end
    end

    assign s_unrec_err_o = {state_reg == LS_FAILED, unrec_reg};
    assign s_corr_o      = corr_reg;
    assign s_fault_rep_o = fault_reg;
    assign s_corr_cnt_o  = cnt_reg;

endmodule

// File: tb/tb_ahb_replica_voter.sv
// Directed bench: a TMR instance (DELAY=2, MAX_RUN=4) and a dual-replica
// instance (DELAY=0), each scenario checked inline against hand-derived values.
module tb_ahb_replica_voter;
    import p_hardisc::*;

    localparam int W = AHB_BUNDLE_W;

    logic         clk;
    logic         rst_n;
    logic         en3, en2;
    logic [W-1:0] rep3 [3];
    logic [W-1:0] rep2 [2];
    logic [W-1:0] bus3, bus2;
    logic [1:0]   err3, err2;
    logic         corr3, corr2;
    logic [1:0]   frep3, frep2;
    logic [7:0]   cnt3, cnt2;

    logic [W-1:0] base;
    int n_checks;
    int n_fail;

    ahb_replica_voter #(.REPLICAS(3), .DELAY(2), .BUS_W(W), .MAX_RUN(4)) dut3 (
        .s_clk_i       (clk),
        .s_resetn_i    (rst_n),
        .s_cmp_en_i    (en3),
        .s_rep_i       (rep3),
        .s_bus_o       (bus3),
        .s_unrec_err_o (err3),
        .s_corr_o      (corr3),
        .s_fault_rep_o (frep3),
        .s_corr_cnt_o  (cnt3)
    );

    ahb_replica_voter #(.REPLICAS(2), .DELAY(0), .BUS_W(W), .MAX_RUN(4)) dut2 (
        .s_clk_i       (clk),
        .s_resetn_i    (rst_n),
        .s_cmp_en_i    (en2),
        .s_rep_i       (rep2),
        .s_bus_o       (bus2),
        .s_unrec_err_o (err2),
        .s_corr_o      (corr2),
        .s_fault_rep_o (frep2),
        .s_corr_cnt_o  (cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set3(input logic [W-1:0] r0, input logic [W-1:0] r1, input logic [W-1:0] r2);
        rep3[0] = r0;
        rep3[1] = r1;
        rep3[2] = r2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en3 = 1'b1;
        en2 = 1'b0;
        set3(base, base, base);
        rep2[0] = base;
        rep2[1] = base;
        tick();
        tick();
        n_checks++; if (bus3 !== base) begin n_fail++; $display("FAIL reset_bus: got %h expected %h", bus3, base); end
        n_checks++; if (err3 !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b expected 00", err3); end
        n_checks++; if (corr3 !== 1'b0) begin n_fail++; $display("FAIL reset_corr: got %b expected 0", corr3); end
        n_checks++; if (frep3 !== 2'd0) begin n_fail++; $display("FAIL reset_frep: got %0d expected 0", frep3); end
        n_checks++; if (cnt3 !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt3); end
        n_checks++; if (dut3.state_reg !== LS_OK) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dut3.state_reg, LS_OK); end
        $display("test_reset: bus=%h err=%b cnt=%0d", bus3, err3, cnt3);
    endtask

    task automatic test_warmup_correction();
        logic [W-1:0] flip5;
        flip5 = base ^ (W'(1) << 5);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            set3(base, base ^ W'(1), base ^ W'(2));
            tick();
            n_checks++; if (corr3 !== 1'b0 || err3 !== 2'b00) begin n_fail++; $display("FAIL warmup_c%0d: got corr=%b err=%b expected corr=0 err=00", c, corr3, err3); end
        end
        set3(base, flip5, base);
        #1;
        n_checks++; if (bus3 !== base) begin n_fail++; $display("FAIL corr_bus: got %h expected %h", bus3, base); end
        tick();
        n_checks++; if (corr3 !== 1'b1) begin n_fail++; $display("FAIL corr_pulse: got %b expected 1", corr3); end
        n_checks++; if (frep3 !== 2'd1) begin n_fail++; $display("FAIL corr_frep: got %0d expected 1", frep3); end
        n_checks++; if (cnt3 !== 8'd1) begin n_fail++; $display("FAIL corr_cnt: got %0d expected 1", cnt3); end
        n_checks++; if (err3 !== 2'b00) begin n_fail++; $display("FAIL corr_err: got %b expected 00", err3); end
        n_checks++; if (dut3.state_reg !== LS_CORRECTING) begin n_fail++; $display("FAIL corr_state: got %0d expected %0d", dut3.state_reg, LS_CORRECTING); end
        set3(base, base, base);
        tick();
        n_checks++; if (corr3 !== 1'b0) begin n_fail++; $display("FAIL clean_corr: got %b expected 0", corr3); end
        n_checks++; if (dut3.state_reg !== LS_OK) begin n_fail++; $display("FAIL clean_state: got %0d expected %0d", dut3.state_reg, LS_OK); end
        n_checks++; if (cnt3 !== 8'd1) begin n_fail++; $display("FAIL clean_cnt: got %0d expected 1", cnt3); end
        $display("test_warmup_correction: frep=%0d cnt=%0d", frep3, cnt3);
    endtask

    task automatic test_persistent();
        for (int k = 0; k < 4; k++) begin
            set3(base, base, base ^ W'(32'h0000_0F00));
            tick();
            n_checks++; if (corr3 !== 1'b1 || frep3 !== 2'd2) begin n_fail++; $display("FAIL persist_k%0d: got corr=%b frep=%0d expected corr=1 frep=2", k, corr3, frep3); end
            n_checks++; if (cnt3 !== 8'(k + 2)) begin n_fail++; $display("FAIL persist_cnt_k%0d: got %0d expected %0d", k, cnt3, k + 2); end
            n_checks++; if (err3[1] !== (k == 3)) begin n_fail++; $display("FAIL persist_failed_k%0d: got %b expected %b", k, err3[1], (k == 3)); end
        end
        for (int k = 0; k < 3; k++) begin
            set3(base, base, base);
            tick();
            n_checks++; if (err3 !== 2'b10 || corr3 !== 1'b0) begin n_fail++; $display("FAIL sticky_k%0d: got err=%b corr=%b expected err=10 corr=0", k, err3, corr3); end
        end
        n_checks++; if (cnt3 !== 8'd5) begin n_fail++; $display("FAIL sticky_cnt: got %0d expected 5", cnt3); end
        $display("test_persistent: err=%b cnt=%0d", err3, cnt3);
    endtask

    task automatic test_reset_in_failed();
        rst_n = 1'b0;
        #1;
        n_checks++; if (err3 !== 2'b00 || corr3 !== 1'b0) begin n_fail++; $display("FAIL rst_fail_flags: got err=%b corr=%b expected err=00 corr=0", err3, corr3); end
        n_checks++; if (cnt3 !== 8'd0 || frep3 !== 2'd0) begin n_fail++; $display("FAIL rst_fail_cnt: got cnt=%0d frep=%0d expected 0 0", cnt3, frep3); end
        n_checks++; if (dut3.state_reg !== LS_OK) begin n_fail++; $display("FAIL rst_fail_state: got %0d expected %0d", dut3.state_reg, LS_OK); end
        tick();
        rst_n = 1'b1;
        $display("test_reset_in_failed: err=%b cnt=%0d", err3, cnt3);
    endtask

    task automatic test_double_fault();
        // rep0 leads by 2 cycles: the bit-3 flip driven at c2 aligns with the bit-7 flip at c4
        set3(base, base, base);           tick();
        set3(base, base, base);           tick();
        set3(base ^ W'(8), base, base);   tick();
        n_checks++; if (err3 !== 2'b00 || corr3 !== 1'b0) begin n_fail++; $display("FAIL dbl_pre: got err=%b corr=%b expected 00 0", err3, corr3); end
        set3(base, base, base);           tick();
        set3(base, base ^ W'(32'h80), base);
        #1;
        n_checks++; if (bus3 !== base) begin n_fail++; $display("FAIL dbl_bus: got %h expected %h", bus3, base); end
        tick();
        n_checks++; if (err3 !== 2'b11 || corr3 !== 1'b0) begin n_fail++; $display("FAIL dbl_err: got err=%b corr=%b expected 11 0", err3, corr3); end
        set3(base, base, base);
        tick();
        n_checks++; if (err3 !== 2'b10) begin n_fail++; $display("FAIL dbl_after: got %b expected 10", err3); end
        $display("test_double_fault: err=%b", err3);
    endtask

    task automatic test_enable_saturation();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        en3 = 1'b0;
        set3(base, base, base); tick();
        set3(base, base, base); tick();
        for (int k = 0; k < 3; k++) begin
            set3(base, base ^ W'(1), base);
            tick();
            n_checks++; if (corr3 !== 1'b0 || err3 !== 2'b00 || cnt3 !== 8'd0) begin n_fail++; $display("FAIL disabled_k%0d: got corr=%b err=%b cnt=%0d expected 0 00 0", k, corr3, err3, cnt3); end
        end
        en3 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) set3(base, base ^ W'(1), base);
            else            set3(base, base, base ^ W'(2));
            tick();
            n_checks++; if (cnt3 !== 8'((i + 1 > 255) ? 255 : i + 1)) begin n_fail++; $display("FAIL sat_cnt_i%0d: got %0d expected %0d", i, cnt3, (i + 1 > 255) ? 255 : i + 1); end
        end
        n_checks++; if (corr3 !== 1'b1 || frep3 !== 2'd2) begin n_fail++; $display("FAIL sat_pulse: got corr=%b frep=%0d expected 1 2", corr3, frep3); end
        n_checks++; if (err3 !== 2'b00) begin n_fail++; $display("FAIL sat_err: got %b expected 00", err3); end
        set3(base, base, base);
        tick();
        $display("test_enable_saturation: cnt=%0d", cnt3);
    endtask

    task automatic test_two_replica();
        logic [W-1:0] v0, v1;
        v0 = {32'h0000_1000, base[W-33:0]};
        v1 = {32'h0000_1004, base[W-33:0]};
        en2 = 1'b1;
        rep2[0] = v0;
        rep2[1] = v0;
        tick();
        n_checks++; if (err2 !== 2'b00 || corr2 !== 1'b0) begin n_fail++; $display("FAIL dual_clean: got err=%b corr=%b expected 00 0", err2, corr2); end
        rep2[1] = v1;
        #1;
        n_checks++; if (bus2 !== v0) begin n_fail++; $display("FAIL dual_bus: got %h expected %h", bus2, v0); end
        tick();
        n_checks++; if (err2 !== 2'b11 || corr2 !== 1'b0) begin n_fail++; $display("FAIL dual_err: got err=%b corr=%b expected 11 0", err2, corr2); end
        rep2[1] = v0;
        tick();
        n_checks++; if (err2 !== 2'b10) begin n_fail++; $display("FAIL dual_after: got %b expected 10", err2); end
        n_checks++; if (cnt2 !== 8'd0 || frep2 !== 2'd0) begin n_fail++; $display("FAIL dual_cnt: got cnt=%0d frep=%0d expected 0 0", cnt2, frep2); end
        $display("test_two_replica: bus=%h err=%b", bus2, err2);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        base = {32'h0000_2000, 32'hDEAD_BEEF, 27'h155_AA55};
        test_reset();
        test_warmup_correction();
        test_persistent();
        test_reset_in_failed();
        test_double_fault();
        test_enable_saturation();
        test_two_replica();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
